// File: rtl/risc15_pkg.sv
// Shared widths and sequencer state encoding for the risc15 load/store-multiple path.
package risc15_pkg;

    localparam int ADDR_W = 16;
    localparam int MASK_W = 8;
    localparam int REG_W  = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/prio_enc8.sv
// Lowest-set-bit encoder: picks the next register to transfer from the remaining mask.
module prio_enc8
    import risc15_pkg::*;
(
    input  logic [MASK_W-1:0] req,
    output logic [REG_W-1:0]  idx,
    output logic              valid
);

    // Scan from the top down so the lowest set bit is the last to write idx.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = REG_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks an 8-bit register mask in ascending order, issuing one
// memory transfer per set bit at consecutive addresses, with a write-back cycle for loads.
module lm_sm_sequencer
    import risc15_pkg::*;
(
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [MASK_W-1:0] imm8,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [REG_W-1:0]  rf_radd,
    output logic [REG_W-1:0]  rf_wadd,
    output logic              rf_wen,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  xfer_cnt
);

    seq_state_e        state, state_n;
    logic [MASK_W-1:0] mask, mask_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              store_q, store_n;
    logic [REG_W-1:0]  wadd_q, wadd_n;
    logic [REG_W-1:0]  idx;
    logic              idx_valid;
    logic [MASK_W-1:0] idx_onehot;

    prio_enc8 u_prio_enc8 (
        .req   (mask),
        .idx   (idx),
        .valid (idx_valid)
    );

    assign idx_onehot = MASK_W'(1) << idx;
    assign rf_wadd    = wadd_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the asynchronous reset also aborts any operation in flight.
    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            state    <= S_IDLE;
            mask     <= '0;
            addr     <= '0;
            xfer_cnt <= '0;
            store_q  <= 1'b0;
            wadd_q   <= '0;
        end else begin
            state    <= state_n;
            mask     <= mask_n;
            addr     <= addr_n;
            xfer_cnt <= cnt_n;
            store_q  <= store_n;
            wadd_q   <= wadd_n;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        mask_n   = mask;
        addr_n   = addr;
        cnt_n    = xfer_cnt;
        store_n  = store_q;
        wadd_n   = wadd_q;
        mem_addr = '0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        rf_radd  = '0;
        rf_wen   = 1'b0;
        busy     = (state != S_IDLE);
        done     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    store_n = is_store;
                    mask_n  = imm8;
                    addr_n  = base_addr;
                    cnt_n   = '0;
                    state_n = (imm8 != '0) ? S_XFER : S_DONE;
                end
            end
            S_XFER: begin
                mem_addr = addr;
                rf_radd  = idx;
                mem_wr   = store_q & idx_valid;
                mem_rd   = ~store_q & idx_valid;
                if (!idx_valid) begin
                    state_n = S_DONE;
                end else if (mem_ready) begin
                    if (store_q) begin
                        mask_n  = mask & ~idx_onehot;
                        addr_n  = addr + ADDR_W'(1);
                        cnt_n   = xfer_cnt + CNT_W'(1);
                        state_n = (mask_n == '0) ? S_DONE : S_XFER;
                    end else begin
                        wadd_n  = idx;
                        state_n = S_WB;
                    end
                end
            end
            S_WB: begin
                // Mask is untouched since the read, so idx still names the loaded register.
                rf_wen  = 1'b1;
                mask_n  = mask & ~idx_onehot;
                addr_n  = addr + ADDR_W'(1);
                cnt_n   = xfer_cnt + CNT_W'(1);
                state_n = (mask_n == '0) ? S_DONE : S_XFER;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: transfer-list reference model against random and directed operations.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        proc_rst = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [7:0]  imm8 = '0;
    logic [15:0] base_addr = '0;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [2:0]  rf_radd, rf_wadd;
    logic        rf_wen, busy, done;
    logic [3:0]  xfer_cnt;

    int n_vec = 0;
    int n_err = 0;

    lm_sm_sequencer dut (
        .clk       (clk),
        .proc_rst  (proc_rst),
        .start     (start),
        .is_store  (is_store),
        .imm8      (imm8),
        .base_addr (base_addr),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .rf_radd   (rf_radd),
        .rf_wadd   (rf_wadd),
        .rf_wen    (rf_wen),
        .busy      (busy),
        .done      (done),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     32'(busy),     0);
        check({tag, "_done"},     32'(done),     0);
        check({tag, "_mem_rd"},   32'(mem_rd),   0);
        check({tag, "_mem_wr"},   32'(mem_wr),   0);
        check({tag, "_rf_wen"},   32'(rf_wen),   0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_rf_wadd"},  32'(rf_wadd),  0);
        check({tag, "_rf_radd"},  32'(rf_radd),  0);
        check({tag, "_xfer_cnt"}, 32'(xfer_cnt), 0);
    endtask

    // One LM/SM operation. mode: 0 = memory always ready, 1 = ready every third
    // cycle, 2 = random ready. hold_start keeps start high with junk operands
    // until completion. abort_at >= 0 pulls reset while that transfer is pending.
    task automatic run_op(input logic st, input logic [7:0] m, input logic [15:0] base,
                          input int mode, input bit hold_start, input int abort_at);
        logic [15:0] exp_addr[$];
        logic [2:0]  exp_reg[$];
        logic [2:0]  wb_q[$];
        logic [2:0]  r;
        int          n, k, n_done;
        bit          done_next, expect_wb, in_wb, finished, rdy, strobe, exp_strobe;

        k = 0;
        n_done = 0;
        expect_wb = 0;
        finished = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                exp_addr.push_back(base + 16'(k));
                exp_reg.push_back(3'(i));
                k++;
            end
        end
        n = k;

        @(negedge clk);
        start = 1'b1; is_store = st; imm8 = m; base_addr = base; mem_ready = 1'b0;
        @(negedge clk);
        start = hold_start;
        is_store = 1'($urandom); imm8 = 8'($urandom); base_addr = 16'($urandom);
        done_next = (n == 0);

        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            strobe     = mem_rd | mem_wr;
            in_wb      = expect_wb;
            exp_strobe = !in_wb && exp_addr.size() != 0;
            check("busy",       32'(busy),            1);
            check("done",       32'(done),            32'(done_next));
            check("xfer_cnt",   32'(xfer_cnt),        32'(n_done));
            check("rd_wr_excl", 32'(mem_rd & mem_wr), 0);
            check("rf_wen",     32'(rf_wen),          32'(in_wb));
            check("strobe",     32'(strobe),          32'(exp_strobe));
            if (done_next) begin
                finished = 1;
                if (mode == 0) check("latency", 32'(cyc), 32'((st ? n : 2 * n) + 1));
            end
            done_next = 0;
            expect_wb = 0;

            if (in_wb && wb_q.size() != 0) begin
                r = wb_q.pop_front();
                check("rf_wadd", 32'(rf_wadd), 32'(r));
                n_done++;
                if (n_done == n) done_next = 1;
            end

            case (mode)
                0:       rdy = 1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase

            if (exp_strobe && strobe) begin
                check("mem_wr",   32'(mem_wr),   32'(st));
                check("mem_addr", 32'(mem_addr), 32'(exp_addr[0]));
                check("rf_radd",  32'(rf_radd),  32'(exp_reg[0]));
                if (abort_at >= 0 && (n - exp_addr.size()) == abort_at) begin
                    proc_rst = 1'b0;
                    start = 1'b0;
                    mem_ready = 1'b1;
                    #1;
                    check_all_zero("abort");
                    for (int j = 0; j < 3; j++) begin
                        @(negedge clk);
                        check("abort_hold_done",   32'(done),   0);
                        check("abort_hold_rf_wen", 32'(rf_wen), 0);
                        check("abort_hold_busy",   32'(busy),   0);
                    end
                    mem_ready = 1'b0;
                    proc_rst = 1'b1;
                    return;
                end
                if (rdy) begin
                    void'(exp_addr.pop_front());
                    r = exp_reg.pop_front();
                    if (st) begin
                        n_done++;
                        if (n_done == n) done_next = 1;
                    end else begin
                        wb_q.push_back(r);
                        expect_wb = 1;
                    end
                end
            end

            mem_ready = rdy;
            @(negedge clk);
        end

        if (!finished) check("timeout", 0, 1);
        start = 1'b0;
        mem_ready = 1'b0;
        check("idle_busy",     32'(busy),     0);
        check("idle_done",     32'(done),     0);
        check("idle_xfer_cnt", 32'(xfer_cnt), 32'(n));
    endtask

    initial begin
        proc_rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        proc_rst = 1'b1;

        run_op(1'b1, 8'h05, 16'h0010, 0, 1'b0, -1);
        run_op(1'b0, 8'h81, 16'h0020, 1, 1'b0, -1);
        run_op(1'b0, 8'h00, 16'h1234, 0, 1'b0, -1);
        run_op(1'b1, 8'h00, 16'h4321, 0, 1'b0, -1);
        run_op(1'b1, 8'hFF, 16'hFFFE, 0, 1'b0, -1);
        run_op(1'b0, 8'hFF, 16'hFFFD, 2, 1'b0, -1);
        run_op(1'b0, 8'h2D, 16'h0100, 2, 1'b0, 2);
        run_op(1'b0, 8'h0F, 16'h0200, 0, 1'b0, -1);
        run_op(1'b1, 8'h36, 16'h4000, 0, 1'b1, -1);
        run_op(1'b0, 8'h90, 16'h5000, 2, 1'b1, -1);
        run_op(1'b1, 8'hE0, 16'h6000, 1, 1'b0, 1);
        for (int t = 0; t < 40; t++) begin
            run_op(1'($urandom), 8'($urandom), 16'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port proc_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: request to begin one LM/SM; accepted only in IDLE.
REQ-004 SHALL have port is_store, input, 1 bit: 1 = SM (register to memory), 0 = LM (memory to register); sampled at acceptance.
REQ-005 SHALL have port imm8, input, 8 bits: register mask; bit i set means Ri takes part; sampled at acceptance.
REQ-006 SHALL have port base_addr, input, 16 bits: first memory address (Ra contents); sampled at acceptance.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory completes the current transfer this cycle.
REQ-008 SHALL have port mem_addr, output, 16 bits: transfer address.
REQ-009 SHALL have port mem_rd, output, 1 bit: LM read strobe.
REQ-010 SHALL have port mem_wr, output, 1 bit: SM write strobe.
REQ-011 SHALL have port rf_radd, output, 3 bits: RF read-port-2 address for SM data.
REQ-012 SHALL have port rf_wadd, output, 3 bits: RF write address for LM data.
REQ-013 SHALL have port rf_wen, output, 1 bit: RF write enable for LM write-back.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port xfer_cnt, output, 4 bits: transfers completed in current operation (0..8).

Function
REQ-017 SHALL implement states IDLE, XFER, WB, DONE.
REQ-018 IDLE with start=1: SHALL latch is_store, imm8 into mask, base_addr into addr; clear xfer_cnt; go to XFER if imm8 != 0, else to DONE.
REQ-019 XFER: SHALL set idx = lowest set bit of mask; drive mem_addr=addr, rf_radd=idx, mem_wr=is_store, mem_rd=~is_store.
REQ-020 XFER, mem_ready=0: SHALL hold all outputs and stay (unbounded wait).
REQ-021 XFER, mem_ready=1, SM: SHALL clear mask[idx], increment addr and xfer_cnt; go to DONE if mask becomes zero, else stay in XFER.
REQ-022 XFER, mem_ready=1, LM: SHALL capture idx into rf_wadd and go to WB.
REQ-023 WB: SHALL assert rf_wen for exactly one cycle with rf_wadd; clear mask[idx]; increment addr and xfer_cnt; go to DONE if mask is zero, else to XFER; no mem strobe in WB.
REQ-024 DONE: SHALL pulse done=1 for one cycle, then go to IDLE; xfer_cnt holds its final value until the next acceptance.
REQ-025 Transfers SHALL occur in ascending register order, with addresses base_addr+0, +1, ... one per set bit.
REQ-026 addr SHALL wrap modulo 2^16 (0xFFFF+1 = 0x0000).
REQ-027 start while busy SHALL be ignored, with no queuing; start in the DONE cycle is ignored.
REQ-028 mem_rd and mem_wr SHALL never be high together and SHALL be low outside XFER.
REQ-029 Inputs imm8, base_addr and is_store SHALL be ignored after acceptance.

Reset
REQ-030 proc_rst=0 SHALL asynchronously force IDLE, mask=0, addr=0, xfer_cnt=0, and all outputs 0; this aborts any operation in progress, and no done pulse SHALL follow.
REQ-031 After release, the first accepted start SHALL be sampled on the first rising clk edge with proc_rst=1.

Structure
REQ-032 State encoding and widths (ADDR_W=16, MASK_W=8, REG_W=3) SHALL live in shared package risc15_pkg.
REQ-033 Lowest-set-bit encoding SHALL be a combinational sub-module prio_enc8 (8-bit in, 3-bit index, valid).

Verification
REQ-034 SM with imm8=0x05, base=0x0010, mem_ready=1: writes to 0x0010 (rf_radd=0) and 0x0011 (rf_radd=2); done 3 cycles after acceptance; xfer_cnt=2.
REQ-035 LM with imm8=0x81, base=0x0020, mem_ready high only every third cycle: rf_wen pulses with rf_wadd=0 then 7; each mem_rd is held through the stalls.
REQ-036 imm8=0x00: no mem strobe, done one cycle after acceptance, xfer_cnt=0.
REQ-037 SM with imm8=0xFF, base=0xFFFE: addresses 0xFFFE, 0xFFFF, 0x0000..0x0005; xfer_cnt=8.
REQ-038 proc_rst low during third LM transfer: outputs 0 immediately with no further rf_wen or done; new start after release runs normally.
REQ-039 start pulsed while busy with a different imm8: ignored; the original operation completes unchanged.
